// File: rtl/i2c_apb_pkg.sv
// Shared constants for the APB register front end of the I2C controller:
// register addresses, APB state encoding and STATUS bit positions.
package i2c_apb_pkg;

    // Register map (word-less byte addresses on PADDR)
    localparam int unsigned REG_PRESCALE = 2;  // write-only
    localparam int unsigned REG_STATUS   = 3;  // read-only
    localparam int unsigned REG_CMD      = 4;  // write-only
    localparam int unsigned REG_RX_DATA  = 5;  // read-only
    localparam int unsigned REG_TX_DATA  = 6;  // write-only

    // STATUS register bit positions; all higher bits read as zero
    localparam int BIT_TX_FULL     = 0;
    localparam int BIT_TX_EMPTY    = 1;
    localparam int BIT_RX_FULL     = 2;
    localparam int BIT_RX_EMPTY    = 3;
    localparam int BIT_RX_OVERFLOW = 4;
    localparam int BIT_CORE_BUSY   = 5;

    // APB slave sequencer: one SETUP, one WAIT, then the RESP cycle with PREADY
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_i2c_regs_if.sv
// APB bus bundle between a master (CPU side) and the I2C register block.
interface apb_i2c_regs_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PSLVERR, PRDATA
    );
endinterface

// File: rtl/i2c_apb_fifo.sv
// First-word-fall-through FIFO used for both the TX and RX byte queues.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module i2c_apb_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port
    // NOTE: the storage array has no reset; an entry is only visible after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/apb_i2c_regs.sv
// APB register front end for an I2C engine: PRESCALE and CMD registers,
// a TX FIFO drained by the engine, an RX FIFO filled by the engine and a
// STATUS register with a sticky RX overflow flag. Every transfer takes
// SETUP -> WAIT -> RESP; side effects commit on the edge that ends RESP.
module apb_i2c_regs
    import i2c_apb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_i2c_regs_if.slave       apb,
    output logic [DATA_W-1:0]   prescale,
    output logic [DATA_W-1:0]   cmd,
    output logic                cmd_valid,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                rx_valid,
    input  logic                core_busy
);
    apb_state_t        state_q;
    apb_state_t        state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;

    logic              hit_prescale;
    logic              hit_status;
    logic              hit_cmd;
    logic              hit_rx_data;
    logic              hit_tx_data;
    logic              addr_ok;
    logic              dir_err;
    logic              full_err;
    logic              empty_err;
    logic              xfer_err;
    logic              in_resp;
    logic              commit;

    logic              wr_prescale;
    logic              wr_cmd;
    logic              wr_tx;
    logic              rd_rx;
    logic              rd_status;

    logic              tx_full;
    logic              tx_empty;
    logic              tx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic [DATA_W-1:0] rx_head;
    logic              rx_overflow;
    logic              rx_overflow_set;

    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] prdata;

    // APB sequencer state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // APB sequencer next state; losing PSELx before RESP abandons the transfer
    always_comb begin
        // NOTE: assign the default first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (apb.PSELx && !apb.PENABLE) state_d = ST_SETUP;
            ST_SETUP: state_d = apb.PSELx ? ST_WAIT : ST_IDLE;
            ST_WAIT:  state_d = apb.PSELx ? ST_RESP : ST_IDLE;
            ST_RESP:  state_d = (apb.PSELx && !apb.PENABLE) ? ST_SETUP : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch address, direction and write data as the transfer enters SETUP
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (state_d == ST_SETUP) begin
            addr_q  <= apb.PADDR;
            write_q <= apb.PWRITE;
            wdata_q <= apb.PWDATA;
        end
    end

    // Address decode and error classification from the captured request
    assign hit_prescale = (addr_q == ADDR_W'(REG_PRESCALE));
    assign hit_status   = (addr_q == ADDR_W'(REG_STATUS));
    assign hit_cmd      = (addr_q == ADDR_W'(REG_CMD));
    assign hit_rx_data  = (addr_q == ADDR_W'(REG_RX_DATA));
    assign hit_tx_data  = (addr_q == ADDR_W'(REG_TX_DATA));
    assign addr_ok      = hit_prescale | hit_status | hit_cmd | hit_rx_data | hit_tx_data;
    assign dir_err      = write_q ? (hit_status | hit_rx_data)
                                  : (hit_prescale | hit_cmd | hit_tx_data);

    // A TX write into a full FIFO is fine when the engine pops that same cycle
    assign tx_pop    = tx_valid & tx_ready;
    assign full_err  = write_q & hit_tx_data & tx_full & ~tx_pop;
    assign empty_err = ~write_q & hit_rx_data & rx_empty;
    assign xfer_err  = ~addr_ok | dir_err | full_err | empty_err;

    assign in_resp     = (state_q == ST_RESP);
    assign commit      = in_resp & ~xfer_err;
    assign wr_prescale = commit &  write_q & hit_prescale;
    assign wr_cmd      = commit &  write_q & hit_cmd;
    assign wr_tx       = commit &  write_q & hit_tx_data;
    assign rd_rx       = commit & ~write_q & hit_rx_data;
    assign rd_status   = commit & ~write_q & hit_status;

    // STATUS image, upper bits zero
    always_comb begin
        status_word                  = '0;
        status_word[BIT_TX_FULL]     = tx_full;
        status_word[BIT_TX_EMPTY]    = tx_empty;
        status_word[BIT_RX_FULL]     = rx_full;
        status_word[BIT_RX_EMPTY]    = rx_empty;
        status_word[BIT_RX_OVERFLOW] = rx_overflow;
        status_word[BIT_CORE_BUSY]   = core_busy;
    end

    // Read data is driven only for a successful read in RESP
    always_comb begin
        prdata = '0;
        if (commit && !write_q) begin
            if (hit_status)       prdata = status_word;
            else if (hit_rx_data) prdata = rx_head;
        end
    end

    assign apb.PREADY  = in_resp;
    assign apb.PSLVERR = in_resp & xfer_err;
    assign apb.PRDATA  = prdata;

    // PRESCALE and CMD registers; cmd_valid is a one-cycle strobe after the commit
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prescale  <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= wr_cmd;
            if (wr_prescale) prescale <= wdata_q;
            if (wr_cmd)      cmd      <= wdata_q;
        end
    end

    // Sticky overflow: a new overflow wins over a same-cycle STATUS read clear
    assign rx_overflow_set = rx_valid & rx_full;
    assign rx_push         = rx_valid & ~rx_full;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) rx_overflow <= 1'b0;
        else          rx_overflow <= rx_overflow_set | (rx_overflow & ~rd_status);
    end

    assign tx_valid = ~tx_empty;

    i2c_apb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .push      (wr_tx),
        .push_data (wdata_q),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // The RX side has no backpressure, so a push into a full FIFO is dropped
    // even when an APB read pops in the same cycle.
    i2c_apb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rd_rx),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

endmodule
